// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-digit 7-segment driver: load handshake, serial shift-add-3 BCD
// conversion, then one shared active-low segment bus. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DATA_W + 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 1);

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic               ovfp_q, ovfp_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [DIGITS-1:0]  blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ovfp_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ovfp_q  <= ovfp_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Conversion FSM; overflow is captured at acceptance but published with the result.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        ovfp_d  = ovfp_q;
        adj     = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    ovfp_d  = (64'(value) > MAX_VAL);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    disp_d  = bcd_d;
                    ovf_d   = ovfp_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blank mask is derived from the next display value so seg and display stay in step.
    always_comb begin
        blank = '0;
`ifdef SEG7_LZB_EN
        begin
            logic nz;
            nz = 1'b0;
            for (int i = DIGITS - 1; i > 0; i--) begin
                nz       = nz | (disp_d[i*4 +: 4] != 4'd0);
                blank[i] = ~nz & ~ovf_d;
            end
        end
`endif
    end

    // Scan divider and output registers reload from next-state values every cycle.
    always_comb begin
        int sel;
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        sel  = int'(idx_d);
        an_d = ~(DIGITS'(1) << idx_d);
        if (ovf_d)           seg_d = 7'b0111111;
        else if (blank[sel]) seg_d = 7'b1111111;
        else                 seg_d = dec7(disp_d[sel*4 +: 4]);
    end

    assign busy     = (state_q == CONV);
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a decimal-arithmetic display model.
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int DATA_W   = 14;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [DATA_W-1:0] value = '0;
    logic              busy, overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int tests = 0;
    int fails = 0;
    int shown = 0;

    seg7_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy), .overflow(overflow), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic int pw10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        if (v > pw10(DIGITS) - 1) return 7'b0111111;
`ifdef SEG7_LZB_EN
        if (d > 0 && v < pw10(d)) return 7'b1111111;
`endif
        return glyph((v / pw10(d)) % 10);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle T+1 of the accepted load.
    task automatic do_load(input int v);
        load  = 1'b1;
        value = DATA_W'(v);
        tick();
        load  = 1'b0;
    endtask

    task automatic check_frame(input int v, input string name);
        int cnt [DIGITS];
        int d;
        for (int i = 0; i < DIGITS; i++) cnt[i] = 0;
        for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
            d = -1;
            for (int i = 0; i < DIGITS; i++) if (an == ~(DIGITS'(1) << i)) d = i;
            tests++;
            if (d < 0) begin
                fails++;
                $display("FAIL %s an_onehot: got %b", name, an);
            end else begin
                cnt[d]++;
                if (seg !== exp_seg(v, d)) begin
                    fails++;
                    $display("FAIL %s seg digit%0d: got %b want %b", name, d, seg, exp_seg(v, d));
                end
            end
            tick();
        end
        for (int i = 0; i < DIGITS; i++) begin
            tests++;
            if (cnt[i] != SCAN_DIV) begin
                fails++;
                $display("FAIL %s dwell digit%0d: got %0d want %0d", name, i, cnt[i], SCAN_DIV);
            end
        end
    endtask

    // Checks busy over the conversion and the first post-conversion cycle.
    task automatic run_conv(input int v, input string name);
        int d;
        do_load(v);
        for (int k = 1; k <= DATA_W; k++) begin
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL %s busy T+%0d: got %b want 1", name, k, busy);
            end
            tick();
        end
        shown = v;
        tests++;
        if (busy !== 1'b0 || overflow !== (v > pw10(DIGITS) - 1)) begin
            fails++;
            $display("FAIL %s done busy/ovf: got %b/%b want 0/%b", name, busy, overflow,
                     v > pw10(DIGITS) - 1);
        end
        d = 0;
        for (int i = 0; i < DIGITS; i++) if (an == ~(DIGITS'(1) << i)) d = i;
        tests++;
        if (seg !== exp_seg(v, d)) begin
            fails++;
            $display("FAIL %s first_seg: got %b want %b", name, seg, exp_seg(v, d));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #13;
        tests++;
        if (seg !== 7'b1111111 || an !== '1 || busy !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got seg=%b an=%b busy=%b ovf=%b want 1111111/1111/0/0",
                     seg, an, busy, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_release: got an=%b seg=%b want 1110/1000000", an, seg);
        end
        shown = 0;
        check_frame(0, "reset_frame");
    endtask

    task automatic test_load_1234;
        run_conv(1234, "load1234");
        check_frame(1234, "frame1234");
    endtask

    task automatic test_overflow;
        run_conv(10000, "ovf10000");
        check_frame(10000, "frame10000");
        run_conv(7, "load7");
        check_frame(7, "frame7");
    endtask

    task automatic test_random;
        int v;
        for (int n = 0; n < 10; n++) begin
            v = (n % 3 == 0) ? $urandom_range(0, 99) : $urandom_range(0, (1 << DATA_W) - 1);
            run_conv(v, "random");
            check_frame(v, "frame_random");
        end
    endtask

    task automatic test_back_to_back;
        run_conv(4321, "b2b_first");
        run_conv(98, "b2b_second");
        check_frame(98, "frame_b2b");
    endtask

    task automatic test_drop;
        do_load(2468);
        tick();
        tick();
        load  = 1'b1;
        value = DATA_W'(1111);
        tick();
        load  = 1'b0;
        repeat (DATA_W - 4) tick();
        load  = 1'b1;
        value = DATA_W'(3333);
        tick();
        load  = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_busy_end: got %b want 0", busy);
        end
        check_frame(2468, "frame_drop");
        run_conv(5555, "after_drop");
        check_frame(5555, "frame_after_drop");
    endtask

    task automatic test_reset_mid;
        run_conv(8642, "premid");
        do_load(1357);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (seg !== 7'b1111111 || an !== '1 || busy !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got seg=%b an=%b busy=%b ovf=%b", seg, an, busy, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_frame(0, "frame_mid_reset");
        run_conv(606, "post_reset");
        check_frame(606, "frame_post_reset");
    endtask

`ifdef SEG7_LZB_EN
    task automatic test_lzb;
        run_conv(40, "lzb40");
        check_frame(40, "frame_lzb40");
        run_conv(0, "lzb0");
        check_frame(0, "frame_lzb0");
        run_conv(10000, "lzb_ovf");
        check_frame(10000, "frame_lzb_ovf");
    endtask
`endif

    initial begin
        test_reset();
        test_load_1234();
        test_overflow();
        test_random();
        test_back_to_back();
        test_drop();
        test_reset_mid();
`ifdef SEG7_LZB_EN
        test_lzb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
